// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Bundle between the UART TX arbiter, its requesters and the
//            transmitter. The slave modport is the arbiter's view. The master
//            modport is the environment's view: the requesters and the
//            transmitter together.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            ack;
  logic [ID_W-1:0]               grant_id;
  logic                          grant_valid;

  // Transmitter side
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_busy;

  // Status
  logic                          err_timeout;

  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, grant_id, grant_valid, tx_start, tx_data, err_timeout
  );

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, grant_id, grant_valid, tx_start, tx_data, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking arbiter that shares one UART
//            transmitter among NUM_REQ requesters, byte by byte. It sequences
//            the transmitter's tx_start / tx_busy handshake and flags a
//            transmitter that never goes busy.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,   // 2..8 requesters
  parameter int DATA_WIDTH = 8,   // byte width handed to the transmitter
  parameter int START_TO   = 4    // cycles, counted from tx_start, for tx_busy to rise (>= 2)
) (
  input wire                clk,
  input wire                rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TO + 1);

  // The tx_start cycle (ISSUE) is the first cycle of the busy-rise window,
  // so WAIT_START expires when its own count has reached START_TO-2.
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(START_TO - 2);
  localparam logic [ID_W-1:0]    C_ID_MAX   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]      C_NUM_REQ  = (ID_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] C_ACK_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_START = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic                  r_grant_valid;
  logic                  r_last;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_err_timeout;
  logic [CNT_W-1:0]      r_cnt;

  // --------------------------------------------------------------------------
  // Per-requester byte lanes
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_bytes[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin selection: rotate req so that bit 0 is the rr_ptr requester,
  // find the first set bit, then rotate the offset back into an index.
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_req_rot;
  logic [ID_W-1:0]    w_rot_off;
  logic [ID_W:0]      w_sel_sum;
  logic [ID_W:0]      w_sel_wrap;
  logic [ID_W-1:0]    w_sel;

  assign w_req_rot = NUM_REQ'({bus.req, bus.req} >> r_rr_ptr);

  // Lowest set bit of the rotated request vector wins
  always_comb begin
    w_rot_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_rot_off = ID_W'(i);
      end
    end
  end

  assign w_sel_sum  = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
  assign w_sel_wrap = w_sel_sum - C_NUM_REQ;
  assign w_sel      = (w_sel_sum >= C_NUM_REQ) ? w_sel_wrap[ID_W-1:0]
                                               : w_sel_sum[ID_W-1:0];

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic            w_timeout;   // busy never rose inside the window
  logic            w_done;      // current byte is finished (or given up on)
  logic            w_owner_req; // owner still offering a byte
  logic            w_arb;       // fresh arbitration from IDLE
  logic            w_issue;     // a byte is handed to the transmitter now
  logic [ID_W-1:0] w_issue_id;
  logic [ID_W-1:0] w_ptr_next;

  assign w_timeout   = (r_state == S_WAIT_START) && !bus.tx_busy && (r_cnt == C_CNT_LAST);
  assign w_done      = w_timeout || ((r_state == S_WAIT_DONE) && !bus.tx_busy);
  assign w_owner_req = bus.req[r_grant_id];
  assign w_arb       = (r_state == S_IDLE) && !bus.tx_busy && (|bus.req);

  // A packet in progress goes straight back to the same owner; a dropped
  // request mid-packet is handled as a release below.
  assign w_issue     = w_arb || (w_done && !r_last && w_owner_req);
  assign w_issue_id  = w_arb ? w_sel : r_grant_id;
  assign w_ptr_next  = (r_grant_id == C_ID_MAX) ? '0 : r_grant_id + 1'b1;

  // --------------------------------------------------------------------------
  // Arbiter FSM. All outputs are registered. The start/ack/data for a byte are
  // loaded on the edge that enters ISSUE, so the ISSUE cycle is the cycle in
  // which tx_start and ack are visible: one cycle after req is sampled.
  // --------------------------------------------------------------------------
  // Main state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_last        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_ack         <= '0;
      r_err_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      // Single-cycle pulses
      r_tx_start    <= 1'b0;
      r_ack         <= '0;
      r_err_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Arbitration is taken care of by the issue block below
        end
        S_ISSUE: begin
          r_state <= S_WAIT_START;
          r_cnt   <= '0;
        end
        S_WAIT_START: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (!w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          // Hold until tx_busy falls; completion handled below
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end

      // End of byte: close the packet, or drop the grant if the owner
      // abandoned it. A continuing packet is picked up by the issue block.
      if (w_done) begin
        if (r_last) begin
          r_rr_ptr      <= w_ptr_next;
          r_grant_valid <= 1'b0;
          r_state       <= S_IDLE;
        end else if (!w_owner_req) begin
          r_grant_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      end

      // Hand the selected byte to the transmitter and ack its requester
      if (w_issue) begin
        r_grant_id    <= w_issue_id;
        r_grant_valid <= 1'b1;
        r_tx_start    <= 1'b1;
        r_ack         <= C_ACK_ONE << w_issue_id;
        r_tx_data     <= w_bytes[w_issue_id];
        r_last        <= bus.req_last[w_issue_id];
        r_state       <= S_ISSUE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ack         = r_ack;
  assign bus.grant_id    = r_grant_id;
  assign bus.grant_valid = r_grant_valid;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed bench for uart_tx_arbiter. Requesters are fed from
//            per-requester byte queues. The expected bytes and the expected
//            grant order are queued when stimulus is driven, then popped on
//            every tx_start. A simple transmitter model raises tx_busy one
//            cycle after tx_start and holds it for busy_hold cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #10 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifc ();

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .START_TO   (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;

  int cyc        = 0;
  int starts     = 0;
  int errs       = 0;
  int last_start = 0;

  logic [8:0] feed_q [NR][$];  // {last, data} still to be offered
  logic [7:0] exp_q  [NR][$];  // bytes expected on tx_data, per requester
  int         exp_gnt [$];     // expected grant order

  logic busy_en   = 1'b1;
  logic tx_pend   = 1'b0;
  int   busy_cnt  = 0;
  int   busy_hold = 10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present the head of each feed queue on the requester inputs
  task automatic refresh();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (feed_q[i].size() > 0) begin
        h = feed_q[i][0];
        ifc.req[i]               = 1'b1;
        ifc.req_data[i*DW +: DW] = h[7:0];
        ifc.req_last[i]          = h[8];
      end else begin
        ifc.req[i]      = 1'b0;
        ifc.req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] data, input logic last);
    feed_q[id].push_back({last, data});
    exp_q[id].push_back(data);
    refresh();
  endtask

  // One clock: advance the transmitter model, score DUT outputs, feed requesters
  task automatic cycle();
    logic [3:0] oh;
    int         e_gnt;
    int         e_dat;
    @(posedge clk);
    #1;
    cyc++;

    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) ifc.tx_busy = 1'b0;
    end
    if (tx_pend) begin
      tx_pend = 1'b0;
      if (busy_en) begin
        ifc.tx_busy = 1'b1;
        busy_cnt    = busy_hold;
      end
    end

    if (ifc.tx_start === 1'b1 || ifc.ack !== '0) begin
      oh = 4'b0001 << ifc.grant_id;
      chk("start_ack_grant", 32'({ifc.tx_start, ifc.grant_valid, ifc.ack}),
          32'({1'b1, 1'b1, oh}));
      if (ifc.tx_start === 1'b1) begin
        starts++;
        last_start = cyc;
        tx_pend    = 1'b1;
        if (exp_gnt.size() > 0) e_gnt = exp_gnt.pop_front();
        else                    e_gnt = 255;
        chk("grant_order", 32'(ifc.grant_id), 32'(e_gnt));
        if (exp_q[ifc.grant_id].size() > 0) e_dat = 32'(exp_q[ifc.grant_id].pop_front());
        else                                e_dat = 256;
        chk("tx_data", 32'(ifc.tx_data), 32'(e_dat));
      end
    end

    if (ifc.err_timeout === 1'b1) begin
      errs++;
      chk("timeout_latency", 32'(cyc - last_start), 32'(TO));
    end

    for (int i = 0; i < NR; i++) begin
      if (ifc.ack[i] === 1'b1 && feed_q[i].size() > 0) void'(feed_q[i].pop_front());
    end
    refresh();
  endtask

  function automatic bit quiet();
    bit q;
    q = (exp_gnt.size() == 0) && (ifc.grant_valid === 1'b0) &&
        (ifc.tx_busy === 1'b0) && (busy_cnt == 0) && !tx_pend;
    for (int i = 0; i < NR; i++) begin
      if (feed_q[i].size() != 0) q = 1'b0;
    end
    return q;
  endfunction

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !quiet()) begin
      cycle();
      n++;
    end
    chk(tag, 32'(quiet()), 32'd1);
  endtask

  task automatic flush_model();
    for (int i = 0; i < NR; i++) begin
      feed_q[i].delete();
      exp_q[i].delete();
    end
    exp_gnt.delete();
    refresh();
    ifc.tx_busy = 1'b0;
    busy_cnt    = 0;
    tx_pend     = 1'b0;
  endtask

  initial begin
    int n;
    int a0;
    int e0;

    ifc.req      = '0;
    ifc.req_data = '0;
    ifc.req_last = '0;
    ifc.tx_busy  = 1'b0;

    // Reset state
    #5 rst_n = 1'b0;
    repeat (3) cycle();
    chk("rst_outputs", 32'({ifc.ack, ifc.grant_valid, ifc.tx_start, ifc.tx_data, ifc.err_timeout}), 32'd0);
    chk("rst_grant_id", 32'(ifc.grant_id), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("idle_no_grant", 32'(ifc.grant_valid), 32'd0);

    // Single byte from requester 0
    push_byte(0, 8'hA5, 1'b1);
    exp_gnt.push_back(0);
    cycle();
    chk("t1_start_latency", 32'({ifc.tx_start, ifc.ack}), 32'({1'b1, 4'b0001}));
    chk("t1_tx_data", 32'(ifc.tx_data), 32'h00A5);
    cycle();
    chk("t1_start_pulse", 32'({ifc.tx_start, ifc.ack}), 32'd0);
    n = 0;
    while (ifc.tx_busy === 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk("t1_grant_held", 32'(ifc.grant_valid), 32'd1);
    cycle();
    chk("t1_grant_fall", 32'(ifc.grant_valid), 32'd0);
    chk("t1_tx_data_hold", 32'(ifc.tx_data), 32'h00A5);

    // rr_ptr is now 1: requester 1 beats requester 0
    push_byte(0, 8'hB0, 1'b1);
    push_byte(1, 8'hB1, 1'b1);
    exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    wait_quiet("t1_rr_probe_done", 80);

    // Fresh reset, then round robin over requesters 0, 1 and 3
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      push_byte(0, 8'h20 + 8'(k), 1'b1);
      push_byte(1, 8'h30 + 8'(k), 1'b1);
      push_byte(3, 8'h40 + 8'(k), 1'b1);
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
      exp_gnt.push_back(3);
    end
    a0 = starts;
    wait_quiet("rr_done", 200);
    chk("rr_starts", 32'(starts - a0), 32'd6);

    // Packet lock: requester 2 sends three bytes, requester 0 arrives mid-packet
    push_byte(2, 8'h10, 1'b0);
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h12, 1'b1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(2);
    exp_gnt.push_back(2);
    a0 = starts;
    n  = 0;
    while (starts < a0 + 2 && n < 60) begin
      cycle();
      n++;
    end
    chk("lock_second_byte", 32'(starts - a0), 32'd2);
    push_byte(0, 8'h5A, 1'b1);
    exp_gnt.push_back(0);
    wait_quiet("lock_done", 200);
    chk("lock_starts", 32'(starts - a0), 32'd4);

    // Timeout: transmitter never goes busy
    busy_en = 1'b0;
    e0 = errs;
    push_byte(1, 8'hC1, 1'b1);
    exp_gnt.push_back(1);
    wait_quiet("timeout_release", 40);
    push_byte(2, 8'hC2, 1'b1);
    exp_gnt.push_back(2);
    wait_quiet("timeout_next_served", 40);
    chk("timeout_count", 32'(errs - e0), 32'd2);
    busy_en = 1'b1;

    // Abort: requester 3 drops out after a non-last byte (rr_ptr is 3)
    push_byte(3, 8'h77, 1'b0);
    exp_gnt.push_back(3);
    a0 = starts;
    wait_quiet("abort_release", 80);
    repeat (8) cycle();
    chk("abort_no_restart", 32'(starts - a0), 32'd1);
    push_byte(0, 8'h30, 1'b1);
    push_byte(3, 8'h33, 1'b1);
    exp_gnt.push_back(3);
    exp_gnt.push_back(0);
    wait_quiet("abort_rr_kept", 100);

    // Reset while the transmitter is busy mid-packet
    push_byte(1, 8'h41, 1'b0);
    push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b1);
    exp_gnt.push_back(1);
    exp_gnt.push_back(1);
    exp_gnt.push_back(1);
    n = 0;
    while (ifc.tx_busy !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    chk("rst_mid_owned", 32'({ifc.grant_valid, ifc.grant_id}), 32'({1'b1, 2'd1}));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({ifc.ack, ifc.grant_valid, ifc.tx_start, ifc.tx_data, ifc.err_timeout}), 32'd0);
    chk("rst_mid_grant_id", 32'(ifc.grant_id), 32'd0);
    flush_model();
    a0 = starts;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    chk("rst_no_reissue", 32'(starts - a0), 32'd0);
    chk("total_timeouts", 32'(errs), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ on-chip requesters, byte by byte.
- Requesters may hold the grant for a whole multi-byte packet.
- Fairness is round-robin.
- The block sits between the client logic and the TX side of the rs232 serial path, and sequences the transmitter's start/busy handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width handed to the transmitter
- START_TO, 4, max cycles to wait for tx_busy to rise after tx_start

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester byte-valid; held high with data stable until acked
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  byte being offered is the last of its packet
- ack  out  NUM_REQ  one-cycle pulse: byte accepted by the transmitter
- grant_id  out  clog2(NUM_REQ)  index of the current owner
- grant_valid  out  1  a requester owns the transmitter
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  DATA_WIDTH  byte for the transmitter; registered, stable until the next tx_start
- tx_busy  in  1  transmitter is serialising
- err_timeout  out  1  one-cycle pulse: tx_busy failed to rise within START_TO cycles

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; ack=0, tx_start=0, tx_data=0, grant_id=0, grant_valid=0, err_timeout=0.
  - rr pointer=0, so requester 0 has highest priority first.
- IDLE:
  - Waits for tx_busy=0 and any req bit set.
  - Then selects the first set req scanning from rr_ptr upward, with wrap.
  - Registers grant_id, sets grant_valid=1, goes to ISSUE.
- ISSUE, one cycle:
  - If req[grant_id]=1: tx_start=1, tx_data<=req_data[grant_id], ack[grant_id]=1, last_r<=req_last[grant_id]; go to WAIT_START with timeout counter=0.
  - If req[grant_id]=0 (requester dropped mid-packet): no start, no ack; release the grant; go to IDLE.
- Latency: a req sampled high in IDLE gives tx_start and ack in the next cycle.
- WAIT_START:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter. At START_TO, pulse err_timeout and continue as if the byte completed (DONE handling).
- WAIT_DONE:
  - Stays while tx_busy=1. When tx_busy=0, do DONE handling:
  - last_r=0: back to ISSUE with the same grant (packet lock). The requester must have its next byte valid by then.
  - last_r=1: rr_ptr<=grant_id+1 (wrap modulo NUM_REQ), grant_valid<=0, go to IDLE.
- Fairness:
  - After a packet completes, the former owner has lowest priority.
  - Bytes from different requesters never interleave inside a packet.
- Ack and deassertion:
  - ack is high only in ISSUE and only for grant_id.
  - A requester may deassert req or change data the cycle after its ack.
- Simultaneous events:
  - Req rising in the same cycle a packet ends is arbitrated on the next IDLE cycle.
  - Reset asserted mid-packet aborts immediately. tx_start is never re-issued for the aborted byte.
- Non-owners: req toggling by a non-owner while locked has no effect.

Test Plan:
- Single byte, NUM_REQ=4:
  - Stimulus: req=4'b0001, req_data[7:0]=8'hA5, req_last[0]=1; tx_busy goes high 1 cycle after start and holds 10 cycles.
  - Required: tx_start and ack[0] pulse 1 cycle after req; tx_data=8'hA5; grant_valid falls when tx_busy falls; rr_ptr=1.
- Round-robin:
  - Stimulus: req=4'b1011 held, every byte has last=1.
  - Required: grant order 0,1,3,0,1,3; exactly one ack per byte.
- Packet lock:
  - Stimulus: requester 2 sends 8'h10,8'h11,8'h12 (last on 8'h12); req[0] rises during 8'h11.
  - Required: tx_data sequence 10,11,12, then requester 0 is granted.
- Timeout:
  - Stimulus: tx_busy tied 0; requester 1 sends a single byte with last=1.
  - Required: err_timeout pulses 4 cycles after tx_start; arbiter returns to IDLE; the next request is served.
- Abort:
  - Stimulus: requester 3 sends a non-last byte, then drops req before the next ISSUE.
  - Required: no further tx_start; grant released; rr_ptr unchanged.
  - Stimulus: rst_n pulsed low during WAIT_DONE.
  - Required: all outputs 0 immediately; grant_id=0.
